// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seqdet_pkg;

    localparam logic [7:0] SEQ_DEFAULT_PAT = 8'b0001_0010;
    localparam int         SEQ_DEFAULT_LEN = 5;
    localparam bit         SEQ_DEFAULT_OVL = 1'b1;

    // Width of the compare datapath; bounds the largest supported MAX_LEN.
    localparam int MASK_W = 64;

    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic logic [MASK_W-1:0] low_mask(input int n);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seqdet_history.sv
// Bit history shift register (newest bit at index 0) with a saturating fill count.
// Clear has priority over shift; both take effect at the rising edge.
module seqdet_history
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int FILL_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift,
    input  logic              clear,
    input  logic              din,
    output logic [MAX_LEN-2:0] hist,
    output logic [FILL_W-1:0]  fill
);

    logic [MAX_LEN-1:0] hist_ext;

    assign hist_ext = {hist, din};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_ext[MAX_LEN-2:0];
            if (fill < FILL_W'(MAX_LEN - 1)) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/seqdet_mealy_param.sv
// Runtime-programmable Mealy sequence detector with overlap control and saturating match counter.
// res is combinational in the cycle of the last pattern bit; match_count follows one edge later.
module seqdet_mealy_param
    import seqdet_pkg::*;
#(
    parameter int                  MAX_LEN     = 8,
    parameter int                  CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]  DEFAULT_PAT = MAX_LEN'(SEQ_DEFAULT_PAT),
    parameter int                  DEFAULT_LEN = SEQ_DEFAULT_LEN,
    parameter bit                  DEFAULT_OVL = SEQ_DEFAULT_OVL,
    localparam int                 LEN_W       = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data,
    input  logic               data_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               res,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;

    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MASK_W-1:0]  mask;
    logic [MASK_W-1:0]  window_ext;
    logic [MASK_W-1:0]  pat_ext;
    logic               fill_ok;
    logic               pat_hit;
    logic               accept;
    logic               hist_clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_pat <= DEFAULT_PAT;
            cfg_len <= LEN_W'(DEFAULT_LEN);
            cfg_ovl <= DEFAULT_OVL;
            cfg_err <= 1'b0;
        end else if (cfg_load) begin
            cfg_pat <= pattern;
            cfg_len <= pat_len;
            cfg_ovl <= overlap;
            cfg_err <= (pat_len == '0) || (pat_len > LEN_W'(MAX_LEN));
        end
    end

    // Only the low cfg_len bits of the incoming window take part in the compare.
    assign mask       = low_mask(int'(cfg_len));
    assign window_ext = MASK_W'({hist, data});
    assign pat_ext    = MASK_W'(cfg_pat);
    assign pat_hit    = (window_ext & mask) == (pat_ext & mask);

    // cfg_len - 1 may wrap when cfg_len is 0, but cfg_err masks that case.
    assign fill_ok    = fill >= (cfg_len - LEN_W'(1));

    assign res        = data_valid & ~cfg_err & ~cfg_load & fill_ok & pat_hit;
    assign accept     = data_valid & ~cfg_load;
    assign hist_clear = cfg_load | (res & ~cfg_ovl);

    seqdet_history #(
        .MAX_LEN (MAX_LEN),
        .FILL_W  (LEN_W)
    ) u_history (
        .clk   (clk),
        .reset (reset),
        .shift (accept),
        .clear (hist_clear),
        .din   (data),
        .hist  (hist),
        .fill  (fill)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_count <= '0;
        end else if (cfg_load) begin
            match_count <= '0;
        end else if (res && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/seqdet_mealy_param.md
Name: seqdet_mealy_param

Overview:
- Parametrised successor of the fixed-pattern Mealy sequence detector.
- Detects a runtime-programmable serial bit pattern, 1..MAX_LEN bits long, on a 1-bit input stream gated by a valid strobe.
- Supports overlapping and non-overlapping detection modes and keeps a saturating match counter.
- Sits beside the serial front-end; `res` is a same-cycle (Mealy) match flag.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of match counter.
- DEFAULT_PAT, 8'b0001_0010, pattern after reset (low DEFAULT_LEN bits used).
- DEFAULT_LEN, 5, pattern length after reset.
- DEFAULT_OVL, 1, overlap mode after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- data  in  1  serial input bit.
- data_valid  in  1  data is sampled only when 1.
- cfg_load  in  1  one-cycle strobe; latches pattern/pat_len/overlap.
- pattern  in  MAX_LEN  pattern; bit [pat_len-1] is the first bit received, bit [0] the last.
- pat_len  in  LEN_W  pattern length, where LEN_W = $clog2(MAX_LEN+1).
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- res  out  1  Mealy match flag: combinational from data/data_valid and registered state.
- match_count  out  CNT_W  number of matches, saturating.
- cfg_err  out  1  registered; latched pat_len is 0 or greater than MAX_LEN.

Behaviour:
- Reset (reset=0, asynchronous):
  - hist=0, fill=0, match_count=0, cfg_err=0.
  - Config registers take DEFAULT_PAT / DEFAULT_LEN / DEFAULT_OVL.
  - res=0 regardless of data.
- State:
  - hist: MAX_LEN-1 most recent accepted bits, newest at bit 0.
  - fill: number of valid bits in hist, 0..MAX_LEN-1, saturating.
- res = data_valid & !cfg_err & !cfg_load & (fill >= len-1) & ({hist,data}[len-1:0] == pat[len-1:0]), using latched config.
- Accepted bit (data_valid=1, cfg_load=0), at the rising edge:
  - If res=0: hist <= {hist,data} truncated to MAX_LEN-1 bits; fill <= min(fill+1, MAX_LEN-1).
  - If res=1 and overlap=1: shift as above; match_count increments unless already all-ones.
  - If res=1 and overlap=0: hist <= 0 and fill <= 0, so no bit of the matched pattern is reused; match_count increments as above.
- data_valid=0: no state change; res=0.
- cfg_load=1:
  - Latches pattern, pat_len and overlap; cfg_err <= (pat_len==0 or pat_len>MAX_LEN).
  - Clears hist, fill and match_count.
  - Any data offered in the same cycle is discarded: not shifted in, res=0.
  - New config governs from the next cycle.
- cfg_err=1: res held 0, counter frozen. History still shifts, but this is irrelevant because the next cfg_load clears it.
- pat_len=1: match on every accepted bit equal to pat[0]. In non-overlap mode this is identical, since fill is not used.
- Counter: CNT_W wide; once at 2^CNT_W-1 it holds.
- Reset mid-stream: everything is cleared asynchronously; the first match needs a full pat_len fresh bits after release.
- Latency:
  - res appears in the same cycle as the last pattern bit.
  - match_count is updated one edge later.

Decomposition:
- Package seqdet_pkg holds:
  - LEN_W derivation function.
  - Default pattern/length/overlap constants.
  - Mask helper: low n bits set.
- Sub-module seqdet_history: shift register plus fill counter, with shift/clear inputs.
- Top-level seqdet_mealy_param holds:
  - Config registers.
  - Masked compare.
  - Counter.

Test Plan:
- Defaults, overlap: after reset, stream 1,0,0,1,0,0,1,0 (valid every cycle) -> res=1 on bits 4 and 7 only; match_count=2.
- Non-overlap: cfg_load pattern=10010, len=5, overlap=0; same stream -> res=1 on bit 4 only; match_count=1. Stream 1,0,0,1,0,0,1,0,0,1,0 -> matches on bits 4 and 10; count=2.
- Valid gaps: default config, stream 1,0,0,1,0 with data_valid=0 and data=1 inserted between each bit -> single res=1 on the fifth valid bit; res=0 on all gap cycles.
- Reconfig/error:
  - cfg_load len=0 -> cfg_err=1; 20 random bits -> res never 1, count=0.
  - cfg_load len=3, pattern=011 -> cfg_err=0; stream 0,1,1,1,0,1,1 -> matches on bits 2 and 6.
- Saturation: CNT_W=3, len=1, pattern=1, 10 accepted ones -> res=1 each cycle; match_count stops at 7.
- Async reset: assert reset mid-pattern after 1,0,0,1 -> res=0 and count=0 immediately; after release, a single 0 gives no match; a full 1,0,0,1,0 matches.
